serial_bit_feeder: RTL
======================

# serial_bit_feeder

Upstream stage for the serial sequence detectors. It accepts parallel words over a valid/ready handshake, buffers one word, and shifts it out MSB-first as a single-bit stream `x` with a per-bit strobe. `x` is paced by a bit-enable tick, so the stream drives the detector's `x` input directly at one bit per clock or at a slower rate.

## Interface
- `W`, default 8: data word width, W ≥ 2.
- `clk` input 1: clock, rising-edge active.
- `rst` input 1: asynchronous, active-high reset.
- `din` input W: parallel word, sampled when `din_valid && din_ready`.
- `din_valid` input 1: producer has a word on `din`.
- `din_ready` output 1: holding register empty; `din_ready = !hold_full` (combinational from a register).
- `bit_en` input 1: bit-pacing tick; tie to 1 for one bit per clock.
- `x` output 1: serial data bit, registered.
- `x_valid` output 1: one-clock strobe; `x` carries a new bit this cycle.
- `frame_start` output 1: high with `x_valid` on the first (MSB) bit of each word.
- `busy` output 1: `hold_full || cnt != 0`.

## Operation
- Storage:
  - holding register `hold[W-1:0]` with flag `hold_full`;
  - shift register `sh` (W bits, or W+1 with parity);
  - remaining-bit counter `cnt`, range 0..W.
- States, derived from flags:
  - IDLE: `cnt == 0 && !hold_full`.
  - LOADED: `cnt == 0 && hold_full`.
  - SHIFT: `cnt > 0`.
- Accept: at a posedge with `din_valid && din_ready`, `hold <= din` and `hold_full <= 1`. Accept and drain never coincide: accept needs `hold_full = 0`, drain needs `hold_full = 1`.
- On a posedge with `bit_en = 1`:
  - If `cnt > 0` (SHIFT): `x <= sh[MSB]`, shift `sh` left, `cnt <= cnt-1`, `x_valid <= 1`, `frame_start <= 0`.
  - Else if `hold_full` (LOADED): `x <= hold[W-1]`, load the remaining bits into `sh`, `cnt <=` (bits in frame − 1), `hold_full <= 0`, `x_valid <= 1`, `frame_start <= 1`.
  - Else (IDLE): `x_valid <= 0`, `frame_start <= 0`, `x` holds its value.
- On a posedge with `bit_en = 0`: `x_valid <= 0`, `frame_start <= 0`. `x`, `sh` and `cnt` hold. An accept can still occur.
- Bit order is MSB-first: `din[W-1]` goes out first, `din[0]` last among the data bits.
- Back-to-back words with `bit_en = 1` and `din_valid` held high produce a gapless stream. The hold register refills during SHIFT, and the next word loads on the edge after `cnt` reaches 0.
- Reset values: `hold_full = 0`, `cnt = 0`, `sh = 0`, `x = 0`, `x_valid = 0`, `frame_start = 0`, `busy = 0`, `din_ready = 1`.
- Reset mid-word discards both the partial word and the held word. No bits are emitted after `rst` is released until a new accept.

## Timing
- Accept at edge N, IDLE, `bit_en = 1`: MSB appears with `x_valid = 1` and `frame_start = 1` after edge N+1. The last data bit appears after edge N+W.
- `din_ready` rises the cycle after the load edge. The next accept is possible one cycle after that.
- `x_valid` is high for exactly one clock per emitted bit and never on two bits without an intervening `bit_en` edge.
- `bit_en` low stalls output. No bit is lost or duplicated across a stall.
- All outputs except `din_ready` and `busy` are registered. Those two are combinational from registers, with no combinational path from `din_valid`.

## Configuration
- `SERIAL_FEEDER_PARITY_EN` defined:
  - each frame is W+1 bits: W data bits, then one even-parity bit (`^din`);
  - `sh` is W+1 bits wide and `cnt` loads W on the load edge;
  - `frame_start` marks the MSB only.
- Not defined: frames are exactly W bits, with no parity logic.

## Test plan
- Reset, then accept `din = 8'hE8` with `bit_en = 1` → `x` = 1,1,1,0,1,0,0,0 on 8 consecutive `x_valid` cycles. First bit one cycle after accept; `frame_start` only on the first bit; `busy` drops after the 8th.
- Words 8'hE8, 8'hE8, 8'h1D with `din_valid` held high → 24 consecutive `x_valid` cycles with no gap. `din_ready` low except for one cycle after each load.
- Accept 8'hA5 with `bit_en` pulsed every 3rd clock → bits 1,0,1,0,0,1,0,1, each `x_valid` exactly one clock, `x` stable between strobes.
- Assert `rst` after the 3rd bit of 8'hFF while 8'h0F is held → outputs at reset values immediately. No further `x_valid` after release until a new accept, which emits the full new word.
- With `SERIAL_FEEDER_PARITY_EN` defined, accept 8'hE9 → 9 bits 1,1,1,0,1,0,0,1,1. Accept 8'hE8 → last bit 0.
- Idle with `din_valid = 0` for 20 cycles → `x_valid = 0`, `busy = 0`, `din_ready = 1` throughout.

Source files
------------

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder: one-word holding buffer, MSB-first bit stream paced by bit_en.
// Define SERIAL_FEEDER_PARITY_EN to append an even-parity bit to every frame.
module serial_bit_feeder #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  input  logic         bit_en,
  output logic         x,
  output logic         x_valid,
  output logic         frame_start,
  output logic         busy
);

`ifdef SERIAL_FEEDER_PARITY_EN
  localparam int FW = W + 1;
`else
  localparam int FW = W;
`endif
  localparam int CW = $clog2(FW + 1);

  typedef enum logic [1:0] {IDLE, LOADED, SHIFT} state_e;

  logic [W-1:0]  hold_q, hold_d;
  logic          hold_full_q, hold_full_d;
  logic [FW-1:0] sh_q, sh_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          x_q, x_d;
  logic          x_valid_q, x_valid_d;
  logic          frame_start_q, frame_start_d;
  logic [FW-1:0] load_vec;
  logic          accept;
  state_e        state;

  // Bits still to go after the MSB, left-aligned so sh[MSB] is always next.
`ifdef SERIAL_FEEDER_PARITY_EN
  assign load_vec = {hold_q[W-2:0], ^hold_q, 1'b0};
`else
  assign load_vec = {hold_q[W-2:0], 1'b0};
`endif

  always_comb begin
    if (cnt_q != '0)      state = SHIFT;
    else if (hold_full_q) state = LOADED;
    else                  state = IDLE;
  end

  assign accept = din_valid && !hold_full_q;

  always_comb begin
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    sh_d          = sh_q;
    cnt_d         = cnt_q;
    x_d           = x_q;
    x_valid_d     = 1'b0;
    frame_start_d = 1'b0;

    if (accept) begin
      hold_d      = din;
      hold_full_d = 1'b1;
    end

    // Accept requires an empty hold register and LOADED requires a full one,
    // so the two updates to hold_full_d never collide.
    if (bit_en) begin
      case (state)
        SHIFT: begin
          x_d       = sh_q[FW-1];
          sh_d      = {sh_q[FW-2:0], 1'b0};
          cnt_d     = cnt_q - CW'(1);
          x_valid_d = 1'b1;
        end
        LOADED: begin
          x_d           = hold_q[W-1];
          sh_d          = load_vec;
          cnt_d         = CW'(FW - 1);
          hold_full_d   = 1'b0;
          x_valid_d     = 1'b1;
          frame_start_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      sh_q          <= '0;
      cnt_q         <= '0;
      x_q           <= 1'b0;
      x_valid_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      sh_q          <= sh_d;
      cnt_q         <= cnt_d;
      x_q           <= x_d;
      x_valid_q     <= x_valid_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign din_ready   = !hold_full_q;
  assign busy        = hold_full_q || (cnt_q != '0);
  assign x           = x_q;
  assign x_valid     = x_valid_q;
  assign frame_start = frame_start_q;

endmodule
